// File: rtl/priority_arbiter_enc_if.sv
// Request/grant bundle for priority_arbiter_enc: N request lines in, one
// encoded grant out with a valid/ready handshake.
interface priority_arbiter_enc_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  // Handshake: the arbiter raises out_valid with a stable out_idx/out_onehot
  // and holds them unchanged until a cycle where out_valid && out_ready are
  // both high; that cycle transfers the grant. out_ready is ignored while
  // out_valid is low, and out_valid never drops before the transfer.
  logic [N-1:0] req;
  logic         rr_mode;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_valid;
  logic         out_ready;

  modport master (
    input  req,
    input  rr_mode,
    input  out_ready,
    output out_idx,
    output out_onehot,
    output out_valid
  );

  modport slave (
    output req,
    output rr_mode,
    output out_ready,
    input  out_idx,
    input  out_onehot,
    input  out_valid
  );
endinterface

// File: rtl/priority_arbiter_enc.sv
// Registered N-input priority arbiter/encoder that holds each grant until accepted.
// Round-robin search, ptr register and rr_mode are enabled by PRIO_ARB_ROUND_ROBIN_EN.
module priority_arbiter_enc #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  priority_arbiter_enc_if.master bus,
  output logic                  o_dbg_state
);
  localparam int W = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_idx;
  logic [W-1:0] w_idx_nxt;
  logic [N-1:0] r_onehot;
  logic [N-1:0] w_onehot_nxt;
  logic         r_valid;
  logic         w_valid_nxt;
  logic         w_handshake;
  logic         w_select;
  logic         w_any;
  logic [W-1:0] w_win;

  // Highest set index wins.
  function automatic logic [W-1:0] fixed_pick(input logic [N-1:0] r);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r[i]) idx = W'(i);
    end
    return idx;
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [W-1:0] idx);
    logic [N-1:0] oh;
    oh = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  assign w_any       = |bus.req;
  assign w_handshake = r_valid && bus.out_ready;
  assign w_select    = (r_state == IDLE) || w_handshake;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr_use;
  logic         r_grant_rr;
  logic         w_grant_rr_nxt;

  function automatic logic [W-1:0] dec_mod(input logic [W-1:0] k);
    return (k == '0) ? W'(N - 1) : k - 1'b1;
  endfunction

  // Winner is the set bit at the smallest downward distance from p (wrapping).
  function automatic logic [W-1:0] rr_pick(input logic [N-1:0] r, input logic [W-1:0] p);
    logic [W-1:0] idx;
    int           best_d;
    int           d;
    idx    = '0;
    best_d = N;
    for (int i = 0; i < N; i++) begin
      d = int'(p) - i;
      if (d < 0) d = d + N;
      if (r[i] && (d < best_d)) begin
        best_d = d;
        idx    = W'(i);
      end
    end
    return idx;
  endfunction

  // A handshake of an rr grant moves ptr below the winner, and the selection
  // made on that same cycle already searches from the moved ptr.
  always_comb begin
    w_ptr_use = r_ptr;
    if (w_handshake && r_grant_rr) w_ptr_use = dec_mod(r_idx);
    w_grant_rr_nxt = r_grant_rr;
    if (w_select && w_any) w_grant_rr_nxt = bus.rr_mode;
    w_win = bus.rr_mode ? rr_pick(bus.req, w_ptr_use) : fixed_pick(bus.req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= W'(N - 1);
      r_grant_rr <= 1'b0;
    end else begin
      r_ptr      <= w_ptr_use;
      r_grant_rr <= w_grant_rr_nxt;
    end
  end
`else
  logic w_unused_rr_mode;
  assign w_unused_rr_mode = bus.rr_mode;
  assign w_win            = fixed_pick(bus.req);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_onehot_nxt = r_onehot;
    w_valid_nxt  = r_valid;
    if (w_select) begin
      if (w_any) begin
        w_state_nxt  = HOLD;
        w_idx_nxt    = w_win;
        w_onehot_nxt = to_onehot(w_win);
        w_valid_nxt  = 1'b1;
      end else begin
        // out_idx deliberately keeps its last value when going idle.
        w_state_nxt  = IDLE;
        w_onehot_nxt = '0;
        w_valid_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_onehot <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_onehot <= w_onehot_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign bus.out_idx    = r_idx;
  assign bus.out_onehot = r_onehot;
  assign bus.out_valid  = r_valid;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_priority_arbiter_enc.sv
// Self-checking bench for priority_arbiter_enc (N=8 and N=5 instances).
module tb_priority_arbiter_enc;
  localparam int N  = 8;
  localparam int W  = 3;
  localparam int N5 = 5;
  localparam int W5 = 3;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  priority_arbiter_enc_if #(.N(N))  bus8 ();
  priority_arbiter_enc_if #(.N(N5)) bus5 ();
  logic dbg8;
  logic dbg5;

  priority_arbiter_enc #(.N(N)) u_dut (
    .clk(clk), .rst(rst), .bus(bus8), .o_dbg_state(dbg8)
  );
  priority_arbiter_enc #(.N(N5)) u_dut5 (
    .clk(clk), .rst(rst), .bus(bus5), .o_dbg_state(dbg5)
  );

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (N=8) ----------------
  logic [W-1:0] exp_q[$];
  int m_ptr   = N - 1;
  bit m_valid = 1'b0;
  int m_idx   = 0;
  bit m_rr    = 1'b0;
  bit m_hs;
  bit m_use_rr;

  // Search order in rr mode: ptr, ptr-1, ..., wrapping; fixed mode: N-1 down to 0.
  function automatic int pick(input logic [N-1:0] r, input bit rr, input int ptr);
    int j;
    for (int off = 0; off < N; off++) begin
      j = rr ? (ptr - off + N) % N : (N - 1 - off);
      if (((r >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ptr   = N - 1;
      m_valid = 1'b0;
      m_idx   = 0;
      m_rr    = 1'b0;
      exp_q.delete();
    end else begin
      m_hs = m_valid && bus8.out_ready;
      if (m_hs && m_rr) m_ptr = (m_idx + N - 1) % N;
      if (!m_valid || m_hs) begin
        if (bus8.req != '0) begin
          m_use_rr = RR_EN && bus8.rr_mode;
          m_idx    = pick(bus8.req, m_use_rr, m_ptr);
          m_valid  = 1'b1;
          m_rr     = m_use_rr;
          exp_q.push_back(W'(m_idx));
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor (N=8) ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", 32'(bus8.out_valid), 32'(m_valid));
      chk("idx", 32'(bus8.out_idx), 32'(m_idx));
      if (!m_valid) begin
        chk("onehot_idle", 32'(bus8.out_onehot), 32'd0);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got valid=%0d expected a queued grant", bus8.out_valid);
      end else begin
        chk("grant_idx", 32'(bus8.out_idx), 32'(exp_q[0]));
        chk("grant_onehot", 32'(bus8.out_onehot), 32'(N'(1) << exp_q[0]));
        if (bus8.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model + monitor (N=5, out_ready tied high) ----------------
  bit m5_valid = 1'b0;
  int m5_idx   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m5_valid = 1'b0;
      m5_idx   = 0;
    end else if (bus5.req != '0) begin
      m5_valid = 1'b1;
      for (int j = 0; j < N5; j++) if (((bus5.req >> j) & 1) != 0) m5_idx = j;
    end else begin
      m5_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("n5_valid", 32'(bus5.out_valid), 32'(m5_valid));
      chk("n5_idx", 32'(bus5.out_idx), 32'(m5_idx));
      chk("n5_range", 32'(bus5.out_idx < W5'(N5)), 32'd1);
      chk("n5_onehot", 32'(bus5.out_onehot), m5_valid ? 32'(N5'(1) << m5_idx) : 32'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [N-1:0] r, input bit rr, input bit rdy);
    bus8.req       = r;
    bus8.rr_mode   = rr;
    bus8.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  int rr_seq[8] = '{7, 2, 0, 7, 2, 0, 7, 2};
  logic [N-1:0] rnd_req;

  initial begin
    bus8.req       = '0;
    bus8.rr_mode   = 1'b0;
    bus8.out_ready = 1'b0;
    bus5.req       = '0;
    bus5.rr_mode   = 1'b0;
    bus5.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("rst_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_onehot", 32'(bus8.out_onehot), 32'd0);
    chk("rst_idx", 32'(bus8.out_idx), 32'd0);
    rst = 1'b0;

    // idle with no requests
    repeat (5) step('0, 1'b0, 1'b1);
    chk("idle_valid", 32'(bus8.out_valid), 32'd0);

    // fixed priority, repeated every cycle
    for (int k = 0; k < 4; k++) begin
      step(8'b0010_0110, 1'b0, 1'b1);
      chk("fixed_idx", 32'(bus8.out_idx), 32'd5);
      chk("fixed_onehot", 32'(bus8.out_onehot), 32'h20);
    end
    step('0, 1'b0, 1'b1);
    chk("fixed_drain", 32'(bus8.out_valid), 32'd0);

    // hold stability
    step(8'b0000_1000, 1'b0, 1'b0);
    chk("hold_first", 32'(bus8.out_idx), 32'd3);
    for (int k = 0; k < 2; k++) begin
      step(8'b1000_0000, 1'b0, 1'b0);
      chk("hold_idx", 32'(bus8.out_idx), 32'd3);
      chk("hold_valid", 32'(bus8.out_valid), 32'd1);
    end
    step(8'b1000_0000, 1'b0, 1'b1);
    chk("hold_next", 32'(bus8.out_idx), 32'd7);
    step('0, 1'b0, 1'b1);
    chk("hold_drain", 32'(bus8.out_valid), 32'd0);

    // round-robin rotation (fixed priority when the feature is absent)
    for (int k = 0; k < 8; k++) begin
      step(8'b1000_0101, 1'b1, 1'b1);
      chk("rr_seq", 32'(bus8.out_idx), RR_EN ? 32'(rr_seq[k]) : 32'd7);
    end
    step('0, 1'b1, 1'b1);

    // reset while holding a grant
    step(8'b0001_0000, 1'b0, 1'b0);
    chk("mid_grant", 32'(bus8.out_idx), 32'd4);
    step(8'b0001_0000, 1'b0, 1'b0);
    rst = 1'b1;
    step(8'hff, 1'b1, 1'b0);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus8.out_valid), 32'd0);
    chk("mid_rst_onehot", 32'(bus8.out_onehot), 32'd0);
    step(8'hff, 1'b1, 1'b1);
    chk("post_rst_rr", 32'(bus8.out_idx), 32'd7);
    step('0, 1'b0, 1'b1);

    // randomized traffic
    repeat (400) begin
      case ($urandom_range(0, 3))
        0:       rnd_req = '0;
        1:       rnd_req = N'(1) << $urandom_range(0, N - 1);
        default: rnd_req = N'($urandom_range(0, (1 << N) - 1));
      endcase
      rst = ($urandom_range(0, 80) == 0);
      step(rnd_req, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      rst = 1'b0;
    end
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // N=5 stimulus: boundary indices, then random requests.
  initial begin
    @(negedge rst);
    bus5.req = 5'b10000;
    @(posedge clk);
    #1;
    chk("n5_top", 32'(bus5.out_idx), 32'd4);
    bus5.req = 5'b00001;
    @(posedge clk);
    #1;
    chk("n5_bottom", 32'(bus5.out_idx), 32'd0);
    repeat (200) begin
      bus5.req = N5'($urandom_range(0, (1 << N5) - 1));
      @(posedge clk);
      #1;
    end
    bus5.req = '0;
  end
endmodule

// File: doc/priority_arbiter_enc.md
# priority_arbiter_enc

Registered, parametrised N-input priority encoder with a valid/ready output handshake and an optional round-robin priority mode. It grows the combinational 4-to-2 encoder into a sequential arbiter that captures the winning request index and holds it stable until a downstream consumer accepts it. It sits between a set of request lines and a single shared consumer, such as a bus master port or a service queue.

## Interface
Parameters:
- N, 8: number of request inputs; must be at least 2.
- W, $clog2(N): width of the encoded index. It is derived and must not be overridden.

Ports:
- clk  input  1  system clock. All logic is clocked on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request lines; bit i set means requester i is active.
- rr_mode  input  1  0 selects fixed priority, 1 selects round-robin. It is sampled only at selection time.
- out_idx  output  W  encoded index of the granted requester.
- out_onehot  output  N  one-hot form of out_idx. It is all zeros when out_valid is 0.
- out_valid  output  1  high when the grant registers hold a result.
- out_ready  input  1  consumer accepts the result when both out_valid and out_ready are high.

## Operation
The FSM has two states, IDLE and HOLD.

Reset values:
- State is IDLE.
- out_valid = 0, out_idx = 0, out_onehot = 0.
- ptr = N-1.

Selection event:
- A selection event occurs in IDLE, or in HOLD on the cycle of a handshake.
- If req is non-zero at a selection event:
  - register the winner into out_idx and out_onehot;
  - set out_valid = 1;
  - move to or stay in HOLD.
- If req is zero at a selection event:
  - set out_valid = 0 and out_onehot = 0;
  - move to IDLE;
  - out_idx keeps its last value.

Fixed priority (rr_mode = 0):
- The highest set index wins: index N-1 has the highest priority and index 0 the lowest.

Round-robin (rr_mode = 1):
- The search order is ptr, ptr-1, …, 0, N-1, …, ptr+1.
- The first set bit in that order wins.
- After a handshake that grants index k, ptr becomes k-1 mod N, so k=0 gives ptr = N-1.
- In fixed mode ptr is not updated.

HOLD behaviour:
- out_idx, out_onehot and out_valid stay stable while out_ready is low.
- Changes on req or rr_mode are ignored until the next selection event.
- A requester that drops its req during HOLD still completes its grant.

Back-to-back handshakes:
- On a handshake cycle the next selection uses the updated ptr.
- This allows one grant per cycle under continuous out_ready.

Width rules:
- out_idx is zero-extended when N is not a power of two.
- Indices at or above N are never produced.

## Timing
- Latency: req sampled at edge t (IDLE) gives out_valid high after edge t, i.e. one cycle.
- Throughput: one grant per cycle when out_ready is held high and req is non-zero.
- Handshake: a grant is consumed only on a cycle where out_valid and out_ready are both high. The valid output never drops before acceptance.
- Reset mid-HOLD: rst high at an edge forces all reset values after that edge. An unaccepted grant is discarded.
- out_ready while out_valid = 0: ignored, with no state change.

## Configuration
Macro: PRIO_ARB_ROUND_ROBIN_EN.
- Defined: the round-robin search, the ptr register and rr_mode are all functional.
- Undefined:
  - the ptr logic is not synthesised;
  - rr_mode is ignored;
  - the block always uses fixed priority;
  - all other behaviour is identical.

## Test plan
1. N=8, after reset: out_valid = 0, out_onehot = 0, out_idx = 0. Then req = 8'b0000_0000 for 5 cycles -> out_valid stays 0.
2. Fixed priority, N=8. Drive req = 8'b0010_0110 with out_ready = 1 -> out_idx = 5 and out_onehot = 8'b0010_0000 one cycle later. The result repeats every cycle while req is unchanged.
3. HOLD stability: req = 8'b0000_1000, out_ready = 0. Grant idx 3 appears; then change req to 8'b1000_0000 -> idx 3 is held until out_ready = 1. Idx 7 is granted on the next cycle.
4. Round-robin, requires PRIO_ARB_ROUND_ROBIN_EN. Set rr_mode = 1, req = 8'b1000_0101, out_ready = 1 continuously -> grants are 7, 2, 0, 7, 2, 0, one per cycle.
5. Reset mid-operation: hold a grant idx 4 with out_ready = 0, then assert rst for 1 cycle -> out_valid = 0 and out_onehot = 0. In round-robin mode ptr returns to N-1, so the next rr grant for req = 8'b1111_1111 is 7.
6. N=5: req = 5'b10000 -> out_idx = 3'd4. req = 5'b00001 -> out_idx = 3'd0. Values 5–7 are never observed.
